// File: rtl/gen_pkg.sv
// gen_pkg: shared definitions for the sweep controller.
//   - PHI_W_DEF / CNT_W_DEF : default widths for the phase and counter paths
//   - state_t               : sweep FSM state encoding
//   - ADDR_*                : register map addresses
package gen_pkg;

  localparam int PHI_W_DEF = 32;
  localparam int CNT_W_DEF = 16;

  // state    | meaning
  // ---------+--------------------------------------------------------
  // IDLE     | waiting for start; config writable
  // PRELOAD  | one cycle: NCO phase reset, sweep registers initialised
  // DWELL    | NCO running, holding phi_inc for the dwell time
  // LOCK     | sweep finished, FLL correcting, waiting for fll_lock
  // DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_DWELL   = 3'd2,
    ST_LOCK    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] ADDR_PHI_START = 3'd0;
  localparam logic [2:0] ADDR_PHI_STEP  = 3'd1;
  localparam logic [2:0] ADDR_N_STEPS   = 3'd2;
  localparam logic [2:0] ADDR_DWELL     = 3'd3;
  localparam logic [2:0] ADDR_CTRL      = 3'd4;

endpackage

// File: rtl/sweep_regs.sv
// sweep_regs: configuration register file for the sweep controller.
//   clk, reset_l         : clock and asynchronous active-low reset
//   wr_en, address, data : single-cycle register write port
//   in_idle              : writes are accepted only while this is high
//   phi_start, phi_step  : sweep start increment and signed step
//   n_steps, dwell       : step count and per-step dwell length
//   fll_handoff          : CTRL bit0, hand over to the FLL after the sweep
module sweep_regs
  import gen_pkg::*;
#(
  parameter int PHI_W = PHI_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             wr_en,
  input  logic [2:0]       address,
  input  logic [31:0]      data,
  input  logic             in_idle,
  output logic [PHI_W-1:0] phi_start,
  output logic [PHI_W-1:0] phi_step,
  output logic [CNT_W-1:0] n_steps,
  output logic [CNT_W-1:0] dwell,
  output logic             fll_handoff
);

  logic [PHI_W-1:0] phi_start_q, phi_start_d;
  logic [PHI_W-1:0] phi_step_q, phi_step_d;
  logic [CNT_W-1:0] n_steps_q, n_steps_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             ctrl_q, ctrl_d;
  logic             wr_ok;

  assign wr_ok = wr_en && in_idle;

  always_comb begin
    phi_start_d = phi_start_q;
    phi_step_d  = phi_step_q;
    n_steps_d   = n_steps_q;
    dwell_d     = dwell_q;
    ctrl_d      = ctrl_q;
    if (wr_ok) begin
      case (address)
        ADDR_PHI_START: phi_start_d = PHI_W'(data);
        ADDR_PHI_STEP:  phi_step_d  = PHI_W'(data);
        ADDR_N_STEPS:   n_steps_d   = CNT_W'(data);
        ADDR_DWELL:     dwell_d     = CNT_W'(data);
        ADDR_CTRL:      ctrl_d      = data[0];
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      phi_start_q <= '0;
      phi_step_q  <= '0;
      n_steps_q   <= '0;
      dwell_q     <= '0;
      ctrl_q      <= 1'b0;
    end else begin
      phi_start_q <= phi_start_d;
      phi_step_q  <= phi_step_d;
      n_steps_q   <= n_steps_d;
      dwell_q     <= dwell_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign phi_start   = phi_start_q;
  assign phi_step    = phi_step_q;
  assign n_steps     = n_steps_q;
  assign dwell       = dwell_q;
  assign fll_handoff = ctrl_q;

endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: NCO frequency sweep sequencer with optional FLL handoff.
//   clk, reset_l          : clock and asynchronous active-low reset
//   wr_en, address, data  : config register writes (accepted in IDLE only)
//   start, abort          : sweep start pulse, abort level
//   fll_lock              : FLL lock indication
//   phi_inc, step_idx     : current NCO increment and sweep step
//   nco_clken, phase_rst  : NCO enable and phase-reset request
//   fll_en, busy, done    : FLL enable, activity flag, completion pulse
// All outputs are registered; they are computed from the next state.
module sweep_ctrl
  import gen_pkg::*;
#(
  parameter int PHI_W = PHI_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             wr_en,
  input  logic [2:0]       address,
  input  logic [31:0]      data,
  input  logic             start,
  input  logic             abort,
  input  logic             fll_lock,
  output logic [PHI_W-1:0] phi_inc,
  output logic             nco_clken,
  output logic             phase_rst,
  output logic             fll_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_idx
);

  logic [PHI_W-1:0] phi_start, phi_step;
  logic [CNT_W-1:0] n_steps, dwell;
  logic             fll_handoff;

  state_t           state_q, state_d;
  logic [PHI_W-1:0] phi_q, phi_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             handoff_q, handoff_d;
  logic             nco_q, nco_d;
  logic             prst_q, prst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] dwell_reload;
  logic [CNT_W-1:0] last_idx;

  sweep_regs #(.PHI_W(PHI_W), .CNT_W(CNT_W)) u_regs (
    .clk        (clk),
    .reset_l    (reset_l),
    .wr_en      (wr_en),
    .address    (address),
    .data       (data),
    .in_idle    (state_q == ST_IDLE),
    .phi_start  (phi_start),
    .phi_step   (phi_step),
    .n_steps    (n_steps),
    .dwell      (dwell),
    .fll_handoff(fll_handoff)
  );

  // Zero dwell / zero steps behave as one; the counter runs reload..0.
  assign dwell_reload = (dwell == '0) ? '0 : dwell - CNT_W'(1);
  assign last_idx     = (n_steps == '0) ? '0 : n_steps - CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    phi_d     = phi_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    handoff_d = handoff_q;
    if (abort) begin
      state_d   = ST_IDLE;
      handoff_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_PRELOAD;
            handoff_d = 1'b0;
          end
        end
        ST_PRELOAD: begin
          state_d = ST_DWELL;
          phi_d   = phi_start;
          idx_d   = '0;
          cnt_d   = dwell_reload;
        end
        ST_DWELL: begin
          if (cnt_q == '0) begin
            if (idx_q == last_idx) begin
              if (fll_handoff) begin
                state_d   = ST_LOCK;
                handoff_d = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              phi_d = phi_q + phi_step;
              idx_d = idx_q + CNT_W'(1);
              cnt_d = dwell_reload;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_LOCK: begin
          if (fll_lock) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    prst_d = (state_d == ST_PRELOAD);
    // After an FLL handoff the NCO keeps running until the next start/abort.
    nco_d  = (state_d == ST_DWELL) || (state_d == ST_LOCK) || handoff_d;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= ST_IDLE;
      phi_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      handoff_q <= 1'b0;
      nco_q     <= 1'b0;
      prst_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phi_q     <= phi_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      handoff_q <= handoff_d;
      nco_q     <= nco_d;
      prst_q    <= prst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign phi_inc   = phi_q;
  assign step_idx  = idx_q;
  assign nco_clken = nco_q;
  assign phase_rst = prst_q;
  assign fll_en    = handoff_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed scoreboard bench for sweep_ctrl.
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        wr_en;
  logic [2:0]  address;
  logic [31:0] data;
  logic        start;
  logic        abort;
  logic        fll_lock;
  logic [31:0] phi_inc;
  logic        nco_clken;
  logic        phase_rst;
  logic        fll_en;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;

  sweep_ctrl #(.PHI_W(32), .CNT_W(16)) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .wr_en    (wr_en),
    .address  (address),
    .data     (data),
    .start    (start),
    .abort    (abort),
    .fll_lock (fll_lock),
    .phi_inc  (phi_inc),
    .nco_clken(nco_clken),
    .phase_rst(phase_rst),
    .fll_en   (fll_en),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] phi;
    logic [15:0] idx;
    logic        nco;
    logic        prst;
    logic        fll;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_phi;
  logic [15:0] m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] phi, input logic [15:0] idx,
                      input logic nco, input logic prst, input logic fll,
                      input logic bsy, input logic dn);
    exp_t e;
    e.tag = tag; e.phi = phi; e.idx = idx; e.nco = nco;
    e.prst = prst; e.fll = fll; e.busy = bsy; e.done = dn;
    exp_q.push_back(e);
    m_phi = phi;
    m_idx = idx;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".phi_inc"},   phi_inc,   32'd0);
    chk({tag, ".step_idx"},  32'(step_idx), 32'd0);
    chk({tag, ".nco_clken"}, 32'(nco_clken), 32'd0);
    chk({tag, ".phase_rst"}, 32'(phase_rst), 32'd0);
    chk({tag, ".fll_en"},    32'(fll_en), 32'd0);
    chk({tag, ".busy"},      32'(busy), 32'd0);
    chk({tag, ".done"},      32'(done), 32'd0);
  endtask

  // Advance one cycle and compare the DUT against the next scoreboard entry.
  task automatic clk_chk();
    exp_t e;
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".phi_inc"},   phi_inc,         e.phi);
      chk({e.tag, ".step_idx"},  32'(step_idx),   32'(e.idx));
      chk({e.tag, ".nco_clken"}, 32'(nco_clken),  32'(e.nco));
      chk({e.tag, ".phase_rst"}, 32'(phase_rst),  32'(e.prst));
      chk({e.tag, ".fll_en"},    32'(fll_en),     32'(e.fll));
      chk({e.tag, ".busy"},      32'(busy),       32'(e.busy));
      chk({e.tag, ".done"},      32'(done),       32'(e.done));
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) clk_chk();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; address = a; data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Expected trace of a sweep: preload, n*dwell cycles, then done + idle
  // unless the sweep ends in an FLL handoff.
  task automatic push_sweep(input logic [31:0] ps, input logic [31:0] st,
                            input int n, input int d, input bit lock);
    int ne;
    int de;
    ne = (n == 0) ? 1 : n;
    de = (d == 0) ? 1 : d;
    push("preload", m_phi, m_idx, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < ne; k++)
      for (int j = 0; j < de; j++)
        push("dwell", ps + st * 32'(k), 16'(k), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    if (!lock) begin
      push("done", m_phi, m_idx, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      push("idle", m_phi, m_idx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    clk_chk();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_l = 1'b0; wr_en = 1'b0; address = '0; data = '0;
    start = 1'b0; abort = 1'b0; fll_lock = 1'b0;
    m_phi = '0; m_idx = '0;
    repeat (2) @(posedge clk);
    #2 reset_l = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset");

    // basic three-step sweep
    wr(3'd0, 32'd36_151_557);
    wr(3'd1, 32'd1000);
    wr(3'd2, 32'd3);
    wr(3'd3, 32'd4);
    wr(3'd4, 32'd0);
    wr(3'd5, 32'hDEAD_BEEF);
    push_sweep(32'd36_151_557, 32'd1000, 3, 4, 1'b0);
    pulse_start();
    drain();

    // phase increment wraps
    wr(3'd0, 32'hFFFF_FFF0);
    wr(3'd1, 32'h0000_0020);
    wr(3'd2, 32'd2);
    wr(3'd3, 32'd1);
    push_sweep(32'hFFFF_FFF0, 32'h20, 2, 1, 1'b0);
    pulse_start();
    drain();

    // FLL handoff
    wr(3'd0, 32'd5000);
    wr(3'd1, 32'd100);
    wr(3'd2, 32'd1);
    wr(3'd3, 32'd2);
    wr(3'd4, 32'd1);
    push_sweep(32'd5000, 32'd100, 1, 2, 1'b1);
    pulse_start();
    drain();
    repeat (7) begin
      push("lock", 32'd5000, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      clk_chk();
    end
    fll_lock = 1'b1;
    push("lock_done", 32'd5000, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    clk_chk();
    fll_lock = 1'b0;
    repeat (3) begin
      push("handoff_idle", 32'd5000, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      clk_chk();
    end
    abort = 1'b1;
    push("handoff_abort", 32'd5000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clk_chk();
    abort = 1'b0;
    wr(3'd4, 32'd0);

    // abort during step 1 of a five-step sweep
    wr(3'd0, 32'd1000);
    wr(3'd1, 32'd10);
    wr(3'd2, 32'd5);
    wr(3'd3, 32'd3);
    push("preload", m_phi, m_idx, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) push("dwell", 32'd1000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push("dwell", 32'd1010, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    repeat (4) clk_chk();
    abort = 1'b1;
    push("abort", 32'd1010, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clk_chk();
    abort = 1'b0;
    repeat (2) begin
      push("post_abort", 32'd1010, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clk_chk();
    end
    wr(3'd0, 32'd7777);
    wr(3'd2, 32'd1);
    wr(3'd3, 32'd1);
    push_sweep(32'd7777, 32'd10, 1, 1, 1'b0);
    pulse_start();
    drain();

    // write during DWELL is dropped
    wr(3'd0, 32'h0000_ABCD);
    wr(3'd1, 32'd1);
    wr(3'd2, 32'd2);
    wr(3'd3, 32'd3);
    push_sweep(32'h0000_ABCD, 32'd1, 2, 3, 1'b0);
    pulse_start();
    clk_chk();
    wr_en = 1'b1; address = 3'd0; data = 32'h0000_1234;
    clk_chk();
    wr_en = 1'b0;
    drain();
    push_sweep(32'h0000_ABCD, 32'd1, 2, 3, 1'b0);
    pulse_start();
    drain();

    // write and start in the same cycle: sweep uses the new value
    wr_en = 1'b1; address = 3'd0; data = 32'h0000_0055;
    push_sweep(32'h0000_0055, 32'd1, 2, 3, 1'b0);
    pulse_start();
    wr_en = 1'b0;
    drain();

    // asynchronous reset mid-DWELL, then default config gives one 1-cycle step
    wr(3'd2, 32'd4);
    wr(3'd3, 32'd5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset.busy", 32'(busy), 32'd1);
    reset_l = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #2;
    reset_l = 1'b1;
    m_phi = '0; m_idx = '0;
    push_sweep(32'd0, 32'd0, 0, 0, 1'b0);
    pulse_start();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
